// File: rtl/weather_alert_responder.sv
// rtl/weather_alert_responder.sv - cockpit response sequencer for weather/emergency alerts
module weather_alert_responder #(
    parameter int BLINK_HALF  = 4,
    parameter int CLEAR_HOLD  = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int GEAR_DELAY  = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] ECSU_state,
    input  logic       severe_weather,
    input  logic       emergency_landing_alert,
    input  logic       pilot_ack,
    output logic       warning_lamp,
    output logic       alarm_buzzer,
    output logic       autopilot_divert,
    output logic       landing_gear_cmd,
    output logic [2:0] response_state,
    output logic [7:0] alert_count
);

    localparam logic [7:0] L_BLINK = 8'(BLINK_HALF);
    localparam logic [7:0] L_CLEAR = 8'(CLEAR_HOLD);
    localparam logic [7:0] L_ACK   = 8'(ACK_TIMEOUT);
    localparam logic [7:0] L_GEAR  = 8'(GEAR_DELAY);

    typedef enum logic [2:0] {
        S_NORMAL  = 3'd0,
        S_CAUTION = 3'd1,
        S_WARN    = 3'd2,
        S_DIVERT  = 3'd3,
        S_LANDING = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_timer;
    logic [7:0] r_clear_cnt;
    logic       r_acked;
    logic       r_severe_d;
    logic       r_lamp;
    logic       r_buzzer;
    logic       r_divert;
    logic       r_gear;
    logic [7:0] r_alert_count;

    logic       w_acked;
    logic       w_changed;
    logic       w_clear_cond;
    logic       w_blink_toggle;
    logic       w_acked_next;
    logic [7:0] w_timer_inc;
    logic [7:0] w_timer_next;
    logic [7:0] w_clear_inc;
    logic [7:0] w_clear_next;
    logic       w_lamp_next;
    logic       w_buzzer_next;
    logic       w_divert_next;
    logic       w_gear_next;
    logic       w_rise;

    always_comb begin
        w_acked     = r_acked | pilot_ack;
        w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;

        w_clear_cond = 1'b0;
        if (r_state == S_CAUTION) begin
            w_clear_cond = (ECSU_state == 2'd0);
        end else if (r_state == S_DIVERT) begin
            w_clear_cond = !severe_weather;
        end
        if (!w_clear_cond) begin
            w_clear_inc = 8'd0;
        end else if (r_clear_cnt == 8'hFF) begin
            w_clear_inc = r_clear_cnt;
        end else begin
            w_clear_inc = r_clear_cnt + 8'd1;
        end

        w_state_next = r_state;
        if (emergency_landing_alert) begin
            w_state_next = S_LANDING;
        end else begin
            case (r_state)
                S_NORMAL: begin
                    // Nonzero ECSU codes without flags are still treated as caution.
                    if (severe_weather)              w_state_next = S_WARN;
                    else if (ECSU_state != 2'd0)     w_state_next = S_CAUTION;
                end
                S_CAUTION: begin
                    if (severe_weather)              w_state_next = S_WARN;
                    else if (w_clear_inc == L_CLEAR) w_state_next = S_NORMAL;
                end
                S_WARN: begin
                    // An ack on the timeout cycle still counts, so it beats DIVERT.
                    if (w_acked && !severe_weather)              w_state_next = S_CAUTION;
                    else if (!w_acked && w_timer_inc == L_ACK)   w_state_next = S_DIVERT;
                end
                S_DIVERT: begin
                    if (w_clear_inc == L_CLEAR)      w_state_next = S_CAUTION;
                end
                S_LANDING: w_state_next = S_LANDING;
                default:   w_state_next = S_NORMAL;
            endcase
        end
        w_changed = (w_state_next != r_state);

        w_blink_toggle = 1'b0;
        if (w_changed) begin
            w_timer_next = 8'd0;
        end else if (r_state == S_LANDING) begin
            w_timer_next = (r_timer >= L_GEAR) ? r_timer : r_timer + 8'd1;
        end else if (r_state == S_CAUTION && w_timer_inc == L_BLINK) begin
            // In CAUTION the timer paces the lamp half-period.
            w_timer_next   = 8'd0;
            w_blink_toggle = 1'b1;
        end else begin
            w_timer_next = w_timer_inc;
        end

        w_clear_next = w_changed ? 8'd0 : w_clear_inc;
        w_acked_next = (w_state_next == S_WARN) && !w_changed && w_acked;

        w_lamp_next   = 1'b0;
        w_buzzer_next = 1'b0;
        w_divert_next = 1'b0;
        w_gear_next   = 1'b0;
        case (w_state_next)
            S_CAUTION: begin
                if (w_changed)           w_lamp_next = 1'b1;
                else if (w_blink_toggle) w_lamp_next = !r_lamp;
                else                     w_lamp_next = r_lamp;
            end
            S_WARN: begin
                w_lamp_next   = 1'b1;
                w_buzzer_next = !w_acked_next;
            end
            S_DIVERT: begin
                w_lamp_next   = 1'b1;
                w_divert_next = 1'b1;
            end
            S_LANDING: begin
                w_lamp_next   = 1'b1;
                w_buzzer_next = 1'b1;
                w_divert_next = 1'b1;
                w_gear_next   = (w_timer_next >= L_GEAR);
            end
            default: ;
        endcase

        w_rise = severe_weather && !r_severe_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_NORMAL;
            r_timer       <= 8'd0;
            r_clear_cnt   <= 8'd0;
            r_acked       <= 1'b0;
            r_severe_d    <= 1'b0;
            r_lamp        <= 1'b0;
            r_buzzer      <= 1'b0;
            r_divert      <= 1'b0;
            r_gear        <= 1'b0;
            r_alert_count <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_clear_cnt <= w_clear_next;
            r_acked     <= w_acked_next;
            r_severe_d  <= severe_weather;
            r_lamp      <= w_lamp_next;
            r_buzzer    <= w_buzzer_next;
            r_divert    <= w_divert_next;
            r_gear      <= w_gear_next;
            if (w_rise && r_alert_count != 8'hFF) begin
                r_alert_count <= r_alert_count + 8'd1;
            end
        end
    end

    assign warning_lamp     = r_lamp;
    assign alarm_buzzer     = r_buzzer;
    assign autopilot_divert = r_divert;
    assign landing_gear_cmd = r_gear;
    assign response_state   = r_state;
    assign alert_count      = r_alert_count;

endmodule

// File: tb/tb_weather_alert_responder.sv
// tb/tb_weather_alert_responder.sv - directed checks for weather_alert_responder
module tb_weather_alert_responder;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] ECSU_state;
    logic       severe_weather;
    logic       emergency_landing_alert;
    logic       pilot_ack;
    logic       warning_lamp;
    logic       alarm_buzzer;
    logic       autopilot_divert;
    logic       landing_gear_cmd;
    logic [2:0] response_state;
    logic [7:0] alert_count;

    int n_cmp = 0;
    int n_err = 0;

    weather_alert_responder dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .ECSU_state              (ECSU_state),
        .severe_weather          (severe_weather),
        .emergency_landing_alert (emergency_landing_alert),
        .pilot_ack               (pilot_ack),
        .warning_lamp            (warning_lamp),
        .alarm_buzzer            (alarm_buzzer),
        .autopilot_divert        (autopilot_divert),
        .landing_gear_cmd        (landing_gear_cmd),
        .response_state          (response_state),
        .alert_count             (alert_count)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {state, lamp, buzzer, divert, gear}
    task automatic chk_out(input string tag, input logic [2:0] st, input logic lamp,
                           input logic buzz, input logic div, input logic gear);
        chk(tag, {1'b0, response_state, warning_lamp, alarm_buzzer, autopilot_divert, landing_gear_cmd},
                 {1'b0, st, lamp, buzz, div, gear});
    endtask

    initial begin
        RST = 1'b1; ECSU_state = 2'd0; severe_weather = 1'b0;
        emergency_landing_alert = 1'b0; pilot_ack = 1'b0;
        step(2);
        RST = 1'b0;
        step(1);
        chk_out("reset_out", 3'd0, 0, 0, 0, 0);
        chk("reset_count", alert_count, 8'd0);

        ECSU_state = 2'd1;
        step(1);  chk_out("caution_entry", 3'd1, 1, 0, 0, 0);
        step(3);  chk_out("caution_e3", 3'd1, 1, 0, 0, 0);
        step(1);  chk_out("caution_toggle1", 3'd1, 0, 0, 0, 0);
        step(4);  chk_out("caution_toggle2", 3'd1, 1, 0, 0, 0);
        step(11); chk_out("caution_e19", 3'd1, 1, 0, 0, 0);

        ECSU_state = 2'd0; step(4);
        ECSU_state = 2'd1; step(1);
        chk_out("glitch_hold", 3'd1, 1, 0, 0, 0);
        ECSU_state = 2'd0; step(7);
        chk_out("clear_7", 3'd1, 0, 0, 0, 0);
        step(1);  chk_out("clear_8_normal", 3'd0, 0, 0, 0, 0);

        ECSU_state = 2'd2; step(1);
        chk_out("ecsu2_caution", 3'd1, 1, 0, 0, 0);
        ECSU_state = 2'd0; step(7);
        chk_out("ecsu2_clear7", 3'd1, 0, 0, 0, 0);
        step(1);  chk_out("ecsu2_normal", 3'd0, 0, 0, 0, 0);

        severe_weather = 1'b1; step(1);
        chk_out("warn_entry", 3'd2, 1, 1, 0, 0);
        chk("alert_1", alert_count, 8'd1);
        step(15); chk_out("warn_e15", 3'd2, 1, 1, 0, 0);
        step(1);  chk_out("divert", 3'd3, 1, 0, 1, 0);
        pilot_ack = 1'b1; step(2);
        chk_out("divert_ack_ignored", 3'd3, 1, 0, 1, 0);
        pilot_ack = 1'b0; severe_weather = 1'b0; step(7);
        chk_out("divert_clear7", 3'd3, 1, 0, 1, 0);
        step(1);  chk_out("divert_to_caution", 3'd1, 1, 0, 0, 0);
        step(8);  chk_out("back_normal", 3'd0, 0, 0, 0, 0);

        severe_weather = 1'b1; step(1);
        chk_out("warn2_entry", 3'd2, 1, 1, 0, 0);
        chk("alert_2", alert_count, 8'd2);
        step(4);
        pilot_ack = 1'b1; step(1);
        chk_out("warn2_acked", 3'd2, 1, 0, 0, 0);
        pilot_ack = 1'b0; step(20);
        chk_out("warn2_no_divert", 3'd2, 1, 0, 0, 0);
        severe_weather = 1'b0; step(1);
        chk_out("warn2_to_caution", 3'd1, 1, 0, 0, 0);
        step(8);  chk_out("normal2", 3'd0, 0, 0, 0, 0);

        severe_weather = 1'b1; step(1);
        step(15); chk_out("warn3_e15", 3'd2, 1, 1, 0, 0);
        pilot_ack = 1'b1; step(1);
        chk_out("ack_at_timeout", 3'd2, 1, 0, 0, 0);
        pilot_ack = 1'b0; step(3);
        chk_out("ack_at_timeout_hold", 3'd2, 1, 0, 0, 0);
        severe_weather = 1'b0; step(1);
        chk_out("warn3_to_caution", 3'd1, 1, 0, 0, 0);
        chk("alert_3", alert_count, 8'd3);

        ECSU_state = 2'd1;
        emergency_landing_alert = 1'b1; step(1);
        chk_out("landing_entry", 3'd4, 1, 1, 1, 0);
        step(9);  chk_out("landing_e9", 3'd4, 1, 1, 1, 0);
        step(1);  chk_out("landing_gear", 3'd4, 1, 1, 1, 1);
        emergency_landing_alert = 1'b0; ECSU_state = 2'd0; step(5);
        chk_out("landing_latched", 3'd4, 1, 1, 1, 1);
        RST = 1'b1; step(1);
        chk_out("landing_reset", 3'd0, 0, 0, 0, 0);
        chk("landing_reset_count", alert_count, 8'd0);
        RST = 1'b0;

        severe_weather = 1'b1; step(50);
        chk("level_counts_once", alert_count, 8'd1);
        for (int i = 0; i < 300; i++) begin
            severe_weather = 1'b0; step(1);
            severe_weather = 1'b1; step(1);
        end
        chk("alert_saturate", alert_count, 8'd255);
        severe_weather = 1'b0; step(1);
        severe_weather = 1'b1; step(50);
        chk("alert_hold_255", alert_count, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
